// File: rtl/spi_flash_reader_if.sv
// Request, word-stream and SPI-master register-bus signals of the flash read sequencer.
// master: the sequencer's view; slave: the surrounding system (requester, consumer, SPI master).
interface spi_flash_reader_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [23:0]     req_addr_i;
  logic [7:0]      req_len_i;
  logic            rd_valid_o;
  logic            rd_ready_i;
  logic [31:0]     rd_data_o;
  logic            busy_o;
  logic            m_stb_o;
  logic [1:0]      m_adr_o;
  logic [3:0]      m_byte_sel_o;
  logic            m_we_o;
  logic [XLEN-1:0] m_dat_o;
  logic [XLEN-1:0] m_dat_i;

  modport master (
    input  req_valid_i, req_addr_i, req_len_i, rd_ready_i, m_dat_i,
    output req_ready_o, rd_valid_o, rd_data_o, busy_o,
           m_stb_o, m_adr_o, m_byte_sel_o, m_we_o, m_dat_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_len_i, rd_ready_i, m_dat_i,
    input  req_ready_o, rd_valid_o, rd_data_o, busy_o,
           m_stb_o, m_adr_o, m_byte_sel_o, m_we_o, m_dat_o
  );
endinterface

// File: rtl/spi_flash_reader.sv
// Serial-flash READ sequencer driving the SPI master register port; streams little-endian words.
// SPI_FLASH_FAST_READ_EN selects opcode 0x0B with one dummy byte after the address.
module spi_flash_reader #(
  parameter logic [15:0] SCK_DIV = 16'd4,
  parameter int          XLEN    = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  spi_flash_reader_if.master bus
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0]  OPCODE    = 8'h0B;
  localparam logic [10:0] HDR_BYTES = 11'd5;
`else
  localparam logic [7:0]  OPCODE    = 8'h03;
  localparam logic [10:0] HDR_BYTES = 11'd4;
`endif

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FLUSH     = 4'd1,
    FLUSH_POP = 4'd2,
    CS_ON     = 4'd3,
    TX_PUSH   = 4'd4,
    TX_WR     = 4'd5,
    RX_POLL   = 4'd6,
    RX_POP    = 4'd7,
    WORD_OUT  = 4'd8,
    CS_OFF    = 4'd9
  } state_t;

  state_t          state_r, state_n;
  logic [23:0]     addr_r;
  logic [8:0]      words_left_r;
  logic [10:0]     byte_cnt_r;
  logic [31:0]     word_r;
  logic [31:0]     rd_data_r;
  logic            req_ready_r, rd_valid_r, busy_r;
  logic            m_stb_r, m_we_r, m_stb_n, m_we_n;
  logic [1:0]      m_adr_r, m_adr_n;
  logic [3:0]      m_sel_r, m_sel_n;
  logic [XLEN-1:0] m_dat_r, m_dat_n;
  logic [7:0]      tx_byte_s;
  logic [1:0]      lane_s;
  logic            is_data_s, accept_s, unused_s;

  function automatic logic [XLEN-1:0] ctrl_word(input logic cs_n);
    return XLEN'({SCK_DIV, 12'h000, 1'b0, 1'b0, cs_n, 1'b1});
  endfunction

  assign accept_s  = bus.req_valid_i && req_ready_r;
  assign is_data_s = (byte_cnt_r >= HDR_BYTES);
  // Lane of the current data byte, counted from the first byte after the header.
  assign lane_s    = byte_cnt_r[1:0] - HDR_BYTES[1:0];
  assign unused_s  = ^bus.m_dat_i[XLEN-1:8];

  // TX byte for the current slot: header bytes, then dummy zeros.
  always_comb begin
    tx_byte_s = 8'h00;
    case (byte_cnt_r)
      11'd0:   tx_byte_s = OPCODE;
      11'd1:   tx_byte_s = addr_r[23:16];
      11'd2:   tx_byte_s = addr_r[15:8];
      11'd3:   tx_byte_s = addr_r[7:0];
      default: tx_byte_s = 8'h00;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:      if (accept_s) state_n = FLUSH; else state_n = IDLE;
      FLUSH:     if (!bus.m_dat_i[1]) state_n = FLUSH_POP; else state_n = CS_ON;
      FLUSH_POP: state_n = FLUSH;
      CS_ON:     state_n = TX_PUSH;
      TX_PUSH:   if (!bus.m_dat_i[2]) state_n = TX_WR; else state_n = TX_PUSH;
      TX_WR:     state_n = RX_POLL;
      RX_POLL:   if (!bus.m_dat_i[1]) state_n = RX_POP; else state_n = RX_POLL;
      RX_POP:    if (is_data_s && (lane_s == 2'd3)) state_n = WORD_OUT; else state_n = TX_PUSH;
      WORD_OUT: begin
        if (bus.rd_ready_i) begin
          if (words_left_r == 9'd1) state_n = CS_OFF; else state_n = TX_PUSH;
        end else begin
          state_n = WORD_OUT;
        end
      end
      CS_OFF:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Bus access for the state being entered, so the strobe is registered with the state.
  always_comb begin
    m_stb_n = 1'b0;
    m_we_n  = 1'b0;
    m_adr_n = 2'b00;
    m_sel_n = 4'b0000;
    m_dat_n = '0;
    case (state_n)
      FLUSH, TX_PUSH, RX_POLL: begin
        m_stb_n = 1'b1; m_adr_n = 2'b01; m_sel_n = 4'b0001;
      end
      FLUSH_POP, RX_POP: begin
        m_stb_n = 1'b1; m_adr_n = 2'b10; m_sel_n = 4'b0001;
      end
      TX_WR: begin
        m_stb_n = 1'b1; m_we_n = 1'b1; m_adr_n = 2'b11; m_sel_n = 4'b0001;
        m_dat_n = {{(XLEN-8){1'b0}}, tx_byte_s};
      end
      CS_ON: begin
        m_stb_n = 1'b1; m_we_n = 1'b1; m_adr_n = 2'b00; m_sel_n = 4'b1111;
        m_dat_n = ctrl_word(1'b0);
      end
      CS_OFF: begin
        m_stb_n = 1'b1; m_we_n = 1'b1; m_adr_n = 2'b00; m_sel_n = 4'b1111;
        m_dat_n = ctrl_word(1'b1);
      end
      default: begin
        m_stb_n = 1'b0;
      end
    endcase
  end

  // State, counters, word assembly and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      addr_r       <= 24'h000000;
      words_left_r <= 9'd0;
      byte_cnt_r   <= 11'd0;
      word_r       <= 32'h0000_0000;
      rd_data_r    <= 32'h0000_0000;
      req_ready_r  <= 1'b0;
      rd_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      m_stb_r      <= 1'b0;
      m_we_r       <= 1'b0;
      m_adr_r      <= 2'b00;
      m_sel_r      <= 4'b0000;
      m_dat_r      <= '0;
    end else begin
      state_r     <= state_n;
      req_ready_r <= (state_n == IDLE);
      rd_valid_r  <= (state_n == WORD_OUT);
      busy_r      <= (state_n != IDLE);
      m_stb_r     <= m_stb_n;
      m_we_r      <= m_we_n;
      m_adr_r     <= m_adr_n;
      m_sel_r     <= m_sel_n;
      m_dat_r     <= m_dat_n;
      if ((state_r == IDLE) && accept_s) begin
        addr_r       <= bus.req_addr_i;
        words_left_r <= (bus.req_len_i == 8'd0) ? 9'd256 : {1'b0, bus.req_len_i};
        byte_cnt_r   <= 11'd0;
      end
      if (state_r == RX_POP) begin
        byte_cnt_r <= byte_cnt_r + 11'd1;
        if (is_data_s) begin
          word_r[{lane_s, 3'b000} +: 8] <= bus.m_dat_i[7:0];
          if (lane_s == 2'd3) begin
            rd_data_r <= {bus.m_dat_i[7:0], word_r[23:0]};
          end
        end
      end
      if ((state_r == WORD_OUT) && bus.rd_ready_i) begin
        words_left_r <= words_left_r - 9'd1;
      end
    end
  end

  assign bus.req_ready_o  = req_ready_r;
  assign bus.rd_valid_o   = rd_valid_r;
  assign bus.rd_data_o    = rd_data_r;
  assign bus.busy_o       = busy_r;
  assign bus.m_stb_o      = m_stb_r;
  assign bus.m_we_o       = m_we_r;
  assign bus.m_adr_o      = m_adr_r;
  assign bus.m_byte_sel_o = m_sel_r;
  assign bus.m_dat_o      = m_dat_r;

endmodule
